// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: flit geometry, flit type codes, input-port
// packet states and the output-port codes exchanged with the RCU.
package noc_pkg;

    localparam int FW    = 39;   // MSB index of a flit (flit is FW+1 bits)
    localparam int DEPTH = 4;    // input buffer entries, power of two
    localparam int AW    = 2;    // log2(DEPTH)

    // Flit type lives in the two MSBs of every flit.
    typedef enum logic [1:0] {
        FT_INV  = 2'b00,
        FT_TAIL = 2'b01,
        FT_BODY = 2'b10,
        FT_HDR  = 2'b11
    } flit_type_e;

    // One-hot packet state presented to the RCU; bit 1 marks ROUTE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_ROUTE  = 3'b010,
        ST_ACTIVE = 3'b100
    } port_state_e;

    // Output-port codes produced by the RCU for the crossbar.
    typedef enum logic [2:0] {
        OP_LOCAL = 3'd0,
        OP_NORTH = 3'd1,
        OP_EAST  = 3'd2,
        OP_SOUTH = 3'd3,
        OP_WEST  = 3'd4
    } out_port_e;

    function automatic flit_type_e flit_type(input logic [FW:0] flit);
        return flit_type_e'(flit[FW:FW-1]);
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Circular flit buffer: DEPTH entries, wrapping pointers, occupancy count.
// A push and a pop in the same cycle are allowed even when full.
module flit_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic         clk_t,
    input  logic         rst_t,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    // Storage write on push.
    // NOTE: the data array is deliberately not reset; occupancy is defined
    // only by the pointers and count, so stale entries are never observed.
    always_ff @(posedge clk_t) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Occupancy after this cycle's push/pop.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_t or negedge rst_t) begin
        if (!rst_t) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

endmodule

// File: rtl/input_port_ctrl.sv
// Router input port: buffers flits, walks each packet through
// IDLE -> ROUTE -> ACTIVE, requests the switch allocator for the buffered
// flits of the current packet, and returns one credit per forwarded flit.
module input_port_ctrl
    import noc_pkg::*;
(
    input  logic        clk_t,
    input  logic        rst_t,
    input  logic [FW:0] flit_in,
    input  logic        valid_in,
    output logic        credit_out,
    output logic [FW:0] flit_out,
    output logic [2:0]  state,
    output logic        req,
    input  logic        grant,
    output logic        drop_err,
    output logic        ovf_err
);

    port_state_e state_q, state_d;
    flit_type_e  head_type;
    logic        full, empty;
    logic        fwd_pop, drop_pop, pop, push, ovf_set;
    logic        credit_q, drop_q, ovf_q;

    flit_fifo #(
        .W     (FW + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_t (clk_t),
        .rst_t (rst_t),
        .push  (push),
        .pop   (pop),
        .wdata (flit_in),
        .rdata (flit_out),
        .full  (full),
        .empty (empty)
    );

    assign head_type = flit_type(flit_out);

    // Packet FSM next state, allocator request and stray-flit discard.
    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        drop_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    if (head_type == FT_HDR) state_d  = ST_ROUTE;
                    else                     drop_pop = 1'b1;
                end
            end
            ST_ROUTE: begin
                // RCU captures its output-port decision at the end of this cycle.
                state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                req = !empty;
                if (req && grant && head_type == FT_TAIL) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A full buffer still accepts a flit when a slot frees in the same cycle.
    assign fwd_pop = req && grant;
    assign pop     = fwd_pop || drop_pop;
    assign push    = valid_in && (!full || pop);
    assign ovf_set = valid_in && full && !pop;

    // State, registered credit/drop pulses and the sticky overflow flag.
    always_ff @(posedge clk_t or negedge rst_t) begin
        if (!rst_t) begin
            state_q  <= ST_IDLE;
            credit_q <= 1'b0;
            drop_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= fwd_pop;
            drop_q   <= drop_pop;
            ovf_q    <= ovf_q || ovf_set;
        end
    end

    assign state      = state_q;
    assign credit_out = credit_q;
    assign drop_err   = drop_q;
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_input_port_ctrl.sv
// Directed and random stimulus for input_port_ctrl, checked every cycle
// against a packet-level queue model of the input port.
module tb_input_port_ctrl;

    localparam int FW    = 39;
    localparam int DEPTH = 4;
    localparam logic [1:0] T_HDR  = 2'b11;
    localparam logic [1:0] T_BODY = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b01;
    localparam logic [1:0] T_INV  = 2'b00;

    logic        clk_t = 1'b0;
    logic        rst_t = 1'b0;
    logic [FW:0] flit_in = '0;
    logic        valid_in = 1'b0;
    logic        grant = 1'b0;
    logic        credit_out, req, drop_err, ovf_err;
    logic [FW:0] flit_out;
    logic [2:0]  state;

    always #5 clk_t = ~clk_t;

    input_port_ctrl dut (
        .clk_t      (clk_t),
        .rst_t      (rst_t),
        .flit_in    (flit_in),
        .valid_in   (valid_in),
        .credit_out (credit_out),
        .flit_out   (flit_out),
        .state      (state),
        .req        (req),
        .grant      (grant),
        .drop_err   (drop_err),
        .ovf_err    (ovf_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: buffered flits in arrival order plus packet phase.
    typedef enum int {P_WAIT, P_ROUTING, P_FORWARD} phase_e;
    logic [FW:0] mq[$];
    phase_e      m_phase = P_WAIT;
    logic        m_credit = 1'b0;
    logic        m_drop = 1'b0;
    logic        m_ovf = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW:0] mk(input logic [1:0] t);
        logic [63:0] r;
        r = {$urandom, $urandom};
        return {t, r[FW-2:0]};
    endfunction

    function automatic logic [2:0] exp_state();
        case (m_phase)
            P_WAIT:    return 3'b001;
            P_ROUTING: return 3'b010;
            default:   return 3'b100;
        endcase
    endfunction

    function automatic logic exp_req();
        return (m_phase == P_FORWARD) && (mq.size() != 0);
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic step(input logic v, input logic [1:0] t, input logic g);
        logic [FW:0] f, head;
        logic [1:0]  ht;
        logic        has, fwd, drop, push;
        f = mk(t);
        valid_in = v;
        flit_in  = f;
        grant    = g;
        @(negedge clk_t);
        check("state", state, exp_state());
        check("req", req, exp_req());
        check("credit_out", credit_out, m_credit);
        check("drop_err", drop_err, m_drop);
        check("ovf_err", ovf_err, m_ovf);
        has = (mq.size() != 0);
        ht  = T_INV;
        if (has) begin
            head = mq[0];
            ht   = head[FW:FW-1];
            check("flit_out", flit_out, head);
        end
        fwd  = exp_req() && g;
        drop = (m_phase == P_WAIT) && has && (ht != T_HDR);
        push = v && (mq.size() < DEPTH || fwd || drop);
        m_ovf    = m_ovf || (v && mq.size() == DEPTH && !(fwd || drop));
        m_credit = fwd;
        m_drop   = drop;
        case (m_phase)
            P_WAIT:    if (has && ht == T_HDR) m_phase = P_ROUTING;
            P_ROUTING: m_phase = P_FORWARD;
            default:   if (fwd && ht == T_TAIL) m_phase = P_WAIT;
        endcase
        if (fwd || drop) void'(mq.pop_front());
        if (push) mq.push_back(f);
        @(posedge clk_t);
        #1;
    endtask

    task automatic idle(input int n, input logic g);
        for (int i = 0; i < n; i++) step(1'b0, T_INV, g);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic reset_mid();
        #2;
        rst_t    = 1'b0;
        valid_in = 1'b0;
        grant    = 1'b0;
        #1;
        check("rst_state", state, 3'b001);
        check("rst_req", req, 1'b0);
        check("rst_credit", credit_out, 1'b0);
        check("rst_drop", drop_err, 1'b0);
        check("rst_ovf", ovf_err, 1'b0);
        mq.delete();
        m_phase  = P_WAIT;
        m_credit = 1'b0;
        m_drop   = 1'b0;
        m_ovf    = 1'b0;
        @(posedge clk_t);
        #1;
        check("rst_hold_state", state, 3'b001);
        rst_t = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] t;
        int r;

        repeat (2) @(posedge clk_t);
        #1;
        check("por_state", state, 3'b001);
        check("por_req", req, 1'b0);
        check("por_credit", credit_out, 1'b0);
        check("por_drop", drop_err, 1'b0);
        check("por_ovf", ovf_err, 1'b0);
        rst_t = 1'b1;

        // Single packet H, B, T with grant held high.
        step(1'b1, T_HDR, 1'b1);
        step(1'b1, T_BODY, 1'b1);
        step(1'b1, T_TAIL, 1'b1);
        idle(6, 1'b1);

        // Fill with grant low, then overflow attempt with no pop.
        step(1'b1, T_HDR, 1'b0);
        step(1'b1, T_BODY, 1'b0);
        step(1'b1, T_BODY, 1'b0);
        step(1'b1, T_BODY, 1'b0);
        step(1'b1, T_TAIL, 1'b0);
        idle(2, 1'b0);
        reset_mid();

        // Refill, then push while full with a pop in the same cycle.
        step(1'b1, T_HDR, 1'b0);
        step(1'b1, T_BODY, 1'b0);
        step(1'b1, T_BODY, 1'b0);
        step(1'b1, T_BODY, 1'b0);
        step(1'b1, T_BODY, 1'b1);
        step(1'b1, T_TAIL, 1'b1);
        idle(8, 1'b1);

        // Stray body and invalid flit while idle.
        step(1'b1, T_BODY, 1'b0);
        idle(3, 1'b0);
        step(1'b1, T_INV, 1'b1);
        idle(3, 1'b1);

        // Back-to-back packets H, T, H, T.
        step(1'b1, T_HDR, 1'b1);
        step(1'b1, T_TAIL, 1'b1);
        step(1'b1, T_HDR, 1'b1);
        step(1'b1, T_TAIL, 1'b1);
        idle(10, 1'b1);

        // Underflow mid-packet: gap between body and tail.
        step(1'b1, T_HDR, 1'b1);
        step(1'b1, T_BODY, 1'b1);
        idle(3, 1'b1);
        step(1'b1, T_TAIL, 1'b1);
        idle(5, 1'b1);

        // Reset in ACTIVE with three flits buffered, right after a pop.
        step(1'b1, T_HDR, 1'b0);
        step(1'b1, T_BODY, 1'b0);
        step(1'b1, T_BODY, 1'b0);
        step(1'b1, T_TAIL, 1'b0);
        idle(1, 1'b0);
        idle(1, 1'b1);
        reset_mid();
        idle(2, 1'b1);
        step(1'b1, T_HDR, 1'b1);
        step(1'b1, T_TAIL, 1'b1);
        idle(6, 1'b1);

        // Random traffic, with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      t = T_HDR;
            else if (r < 6) t = T_BODY;
            else if (r < 9) t = T_TAIL;
            else            t = T_INV;
            step(1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 3) != 0));
            if (i == 200) reset_mid();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
